load_store_unit: RTL and testbench

- Sits between the multicycle core datapath and the data port of the unified memory.
- Accepts one load/store request at a time from the core. Turns it into a word-aligned memory access with byte-lane write mask and replicated write data.
- Waits out the memory read latency, then returns a sign-/zero-extended load result or a store acknowledge.
- Removes byte-lane handling from the core; the core only presents funct3, byte address and register data.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state type,
// the memory-latency counter width and the funct3 legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wide enough for MEM_LATENCY-1 with MEM_LATENCY up to 4.
  localparam int LAT_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } lsu_state_t;

  // Unsigned widths exist only for loads.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: store mask and data replication,
// and load byte/halfword selection with sign or zero extension. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_st_data,
  input  logic [31:0] i_ld_word,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_wmask = 4'b1111;
    o_wdata = i_st_data;
    case (i_funct3[1:0])
      2'b00: begin
        o_wmask = 4'b0001 << i_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        // Halfword lane comes from off[1] only; off[0] is ignored here.
        o_wmask = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_byte = i_ld_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

  always_comb begin
    case (i_funct3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'h000000, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'h0000, w_half};
      F3_W:    o_ld_data = i_ld_word;
      default: o_ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core datapath and the unified memory data port.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into error responses.
//
// state  | meaning
// IDLE   | ready for a request; decode and capture on handshake
// ACCESS | memory strobe cycle (write, or read issue)
// WAIT   | counting down memory read latency, capture on zero
// RESP   | rsp_valid pulse, then back to IDLE
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_t           r_state;
  logic                 r_we;
  logic [2:0]           r_funct3;
  logic [1:0]           r_off;
  logic [LAT_CNT_W-1:0] r_wait_cnt;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic                 r_mem_rden;
  logic                 r_mem_wren;
  logic [3:0]           r_mem_wmask;
  logic [31:0]          r_mem_wdata;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic [31:0]          r_rsp_rdata;

  logic                 w_idle;
  logic [2:0]           w_funct3;
  logic [1:0]           w_off;
  logic                 w_misalign;
  logic                 w_req_err;
  logic [3:0]           w_st_mask;
  logic [31:0]          w_st_data;
  logic [31:0]          w_ld_data;

  assign w_idle = (r_state == IDLE);

  // Store steering is needed at the handshake edge, load extension after capture.
  assign w_funct3 = w_idle ? req_funct3 : r_funct3;
  assign w_off    = w_idle ? req_addr[1:0] : r_off;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = f3_illegal(req_we, req_funct3) | w_misalign;

  lsu_lane_align u_lane_align (
    .i_funct3  (w_funct3),
    .i_off     (w_off),
    .i_st_data (req_wdata),
    .i_ld_word (mem_rdata),
    .o_wmask   (w_st_mask),
    .o_wdata   (w_st_data),
    .o_ld_data (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_off       <= 2'b00;
      r_wait_cnt  <= '0;
      r_mem_addr  <= '0;
      r_mem_rden  <= 1'b0;
      r_mem_wren  <= 1'b0;
      r_mem_wmask <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
    end else begin
      r_mem_rden  <= 1'b0;
      r_mem_wren  <= 1'b0;
      r_mem_wmask <= 4'b0000;
      r_mem_wdata <= 32'h0000_0000;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            if (w_req_err) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0000_0000;
            end else begin
              r_state    <= ACCESS;
              r_mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
              r_mem_wren <= req_we;
              r_mem_rden <= ~req_we;
              if (req_we) begin
                r_mem_wmask <= w_st_mask;
                r_mem_wdata <= w_st_data;
              end
            end
          end
        end
        ACCESS: begin
          if (r_we) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
          end else begin
            r_wait_cnt <= LAT_CNT_W'(MEM_LATENCY - 1);
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_ld_data;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Ready drops with reset itself so nothing is accepted while in reset.
  assign req_ready = reset & w_idle;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_rden  = r_mem_rden;
  assign mem_wren  = r_mem_wren;
  assign mem_wmask = r_mem_wmask;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized requests
// compared against a byte-addressed memory model kept in the bench.
module tb_load_store_unit;

  localparam int LAT = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic        mem_rden;
  logic        mem_wren;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.MEM_LATENCY(LAT), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_rden   (mem_rden),
    .mem_wren   (mem_wren),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference memory: 64 bytes at 0x2000, byte addressed.
  logic [7:0]  mb [64];
  logic        sync_mem;

  // Memory responder with LAT-cycle read latency and byte-masked writes.
  logic [31:0] tb_mem [16];
  logic        rd_v [LAT];
  logic [3:0]  rd_a [LAT];

  always @(posedge clk) begin
    rd_v[0] <= mem_rden;
    rd_a[0] <= mem_addr[5:2];
    for (int i = 1; i < LAT; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_a[i] <= rd_a[i-1];
    end
    if (sync_mem) begin
      for (int i = 0; i < 16; i++)
        tb_mem[i] <= {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
    end else if (mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) tb_mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  assign mem_rdata = rd_v[LAT-1] ? tb_mem[rd_a[LAT-1]] : 32'h5A5A_C3C3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural expectation for one request; updates the model memory for stores.
  task automatic model(input bit we, input bit [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output bit err, output logic [31:0] rd,
                       output logic [31:0] mask, output logic [31:0] wdat, output int lat);
    int size, wb, base;
    logic [31:0] val;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00)) err = 1'b1;
`endif
    wb   = int'(a[5:0]) & 32'h3C;
    base = (size == 1) ? wb + int'(a[1:0]) : (size == 2) ? wb + 2 * int'(a[1]) : wb;
    rd   = 32'h0;
    mask = 32'h0;
    wdat = 32'h0;
    if (err) begin
      lat = 1;
    end else if (we) begin
      lat = 2;
      for (int k = 0; k < size; k++) begin
        mb[base+k] = wd[8*k +: 8];
        mask = mask | (32'h1 << (base - wb + k));
      end
      wdat = (size == 1) ? wd[7:0] * 32'h0101_0101 :
             (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    end else begin
      lat = 2 + LAT;
      val = 32'h0;
      for (int k = 0; k < size; k++) val = val | (32'(mb[base+k]) << (8 * k));
      if (!f3[2] && size == 1 && val[7])  val = val | 32'hFFFF_FF00;
      if (!f3[2] && size == 2 && val[15]) val = val | 32'hFFFF_0000;
      rd = val;
    end
  endtask

  // Issue one request from a negedge; returns at the negedge after the response.
  task automatic do_req(input bit we, input bit [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic [31:0] got_rd);
    bit e_err, got;
    logic [31:0] e_rd, e_mask, e_wd;
    int e_lat, n_wr, n_rd;
    model(we, f3, a, wd, e_err, e_rd, e_mask, e_wd, e_lat);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    check_eq("ready_idle", req_ready, 1);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    n_wr = 0; n_rd = 0; got = 1'b0; got_rd = 32'h0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (mem_wren) begin
        n_wr++;
        check_eq("wr_cycle", c, 1);
        check_eq("wr_addr", mem_addr, a & 32'hFFFF_FFFC);
        check_eq("wr_mask", mem_wmask, e_mask);
        check_eq("wr_data", mem_wdata, e_wd);
      end
      if (mem_rden) begin
        n_rd++;
        check_eq("rd_cycle", c, 1);
        check_eq("rd_addr", mem_addr, a & 32'hFFFF_FFFC);
      end
      if (rsp_valid) begin
        got = 1'b1;
        check_eq("rsp_latency", c, e_lat);
        check_eq("rsp_err", rsp_err, e_err);
        check_eq("rsp_rdata", rsp_rdata, e_rd);
        got_rd = rsp_rdata;
      end else begin
        check_eq("ready_busy", req_ready, 0);
      end
    end
    check_eq("rsp_seen", got, 1);
    check_eq("n_wren", n_wr, (!e_err && we) ? 1 : 0);
    check_eq("n_rden", n_rd, (!e_err && !we) ? 1 : 0);
    @(negedge clk);
    check_eq("rsp_pulse", rsp_valid, 0);
    check_eq("ready_back", req_ready, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, req_ready, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check_eq({tag, "_rsp_err"}, rsp_err, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_strobes"}, {mem_rden, mem_wren}, 0);
    check_eq({tag, "_wmask"}, mem_wmask, 0);
    check_eq({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    logic [31:0] r;
    int extra;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    sync_mem   = 1'b0;
    for (int i = 0; i < 64; i++) mb[i] = 8'($urandom);
    {mb[3], mb[2], mb[1], mb[0]} = 32'h80F0_7F01;
    sync_mem = 1'b1;
    repeat (2) @(negedge clk);
    sync_mem = 1'b0;
    check_all_zero("reset");
    reset = 1'b1;
    #1;
    check_eq("ready_after_reset", req_ready, 1);
    @(negedge clk);

    do_req(0, 3'b000, 32'h2003, 32'h0, 0, r); check_eq("lb_const", r, 32'hFFFF_FF80);
    do_req(0, 3'b100, 32'h2003, 32'h0, 0, r); check_eq("lbu_const", r, 32'h0000_0080);
    do_req(0, 3'b001, 32'h2002, 32'h0, 0, r); check_eq("lh_const", r, 32'hFFFF_80F0);
    do_req(0, 3'b101, 32'h2000, 32'h0, 0, r); check_eq("lhu_const", r, 32'h0000_7F01);
    do_req(0, 3'b010, 32'h2000, 32'h0, 1, r); check_eq("lw_const", r, 32'h80F0_7F01);
    do_req(0, 3'b010, 32'h2000, 32'h0, 0, r); check_eq("lw_held", r, 32'h80F0_7F01);

    do_req(1, 3'b010, 32'h2004, 32'hDEAD_BEEF, 0, r);
    do_req(1, 3'b000, 32'h2007, 32'h0000_00A5, 0, r);
    do_req(1, 3'b001, 32'h2002, 32'h0000_1234, 0, r);
    do_req(0, 3'b010, 32'h2004, 32'h0, 0, r);
    do_req(0, 3'b010, 32'h2000, 32'h0, 0, r); check_eq("sh_readback", r, 32'h1234_7F01);

    do_req(0, 3'b111, 32'h2000, 32'h0, 0, r);
    do_req(1, 3'b100, 32'h2008, 32'h55, 0, r);
    do_req(0, 3'b010, 32'h2002, 32'h0, 0, r);
    do_req(1, 3'b001, 32'h2003, 32'hCAFE, 0, r);

    // Reset during the WAIT phase of a load.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h2010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("mid_wait_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("ready_after_rerelease", req_ready, 1);
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_rden || mem_wren) extra++;
    end
    check_eq("no_activity_after_reset", extra, 0);
    do_req(1, 3'b010, 32'h2010, 32'h0BAD_F00D, 0, r);
    do_req(0, 3'b010, 32'h2010, 32'h0, 0, r); check_eq("sw_after_reset", r, 32'h0BAD_F00D);

    for (int n = 0; n < 80; n++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h2000 | 32'($urandom_range(0, 63)), $urandom, 1'($urandom_range(0, 3) == 0), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
